// File: rtl/button_conditioner.sv
// button_conditioner: conditions one raw, bouncing push-button into a clean
// debounced level plus one-cycle press, release and auto-repeat strobes.
// Pipeline: 2-flop synchroniser -> debounce/repeat FSM -> registered outputs.
// There is no valid/ready handshake here: every output is a free-running
// per-clock signal, and the pulses are single-cycle strobes that need no
// acknowledgement.
module button_conditioner #(
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'b000,
    ST_DEB_PRESS   = 3'b001,
    ST_HELD        = 3'b010,
    ST_REPEAT      = 3'b011,
    ST_DEB_RELEASE = 3'b100
  } state_t;

  // Terminal counts; every compare is below the counter's all-ones value,
  // so the counter can never wrap.
  localparam logic [CNT_W-1:0] L_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] L_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             r_s1;
  logic             r_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_repeat;

  state_t           w_next_state;
  logic             w_cnt_clr;
  logic             w_cnt_sat;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_repeat_nxt;
  logic             w_level_nxt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_s1   <= btn_in;
      r_sync <= r_s1;
    end
  end

  // Next-state and next-output decode for the debounce/repeat FSM.
  always_comb begin
    w_next_state  = r_state;
    w_cnt_clr     = 1'b0;
    w_cnt_sat     = 1'b0;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_repeat_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Nothing is timed while idle, so keep the counter parked at zero.
        w_cnt_clr = 1'b1;
        if (r_sync) begin
          w_next_state = ST_DEB_PRESS;
        end
      end
      ST_DEB_PRESS: begin
        if (!r_sync) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == L_DEB_LAST) begin
          w_next_state = ST_HELD;
          w_press_nxt  = 1'b1;
        end
      end
      ST_HELD: begin
        if (!r_sync) begin
          w_next_state = ST_DEB_RELEASE;
        end else if (r_cnt == L_DLY_LAST) begin
          if (repeat_en) begin
            w_next_state = ST_REPEAT;
            w_repeat_nxt = 1'b1;
          end else begin
            // Hold at the delay terminal so enabling repeat later fires at once.
            w_cnt_sat = 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (!r_sync) begin
          w_next_state = ST_DEB_RELEASE;
        end else if (!repeat_en) begin
          w_next_state = ST_HELD;
        end else if (r_cnt == L_PER_LAST) begin
          w_repeat_nxt = 1'b1;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_DEB_RELEASE: begin
        if (r_sync) begin
          w_next_state = ST_HELD;
        end else if (r_cnt == L_DEB_LAST) begin
          w_next_state  = ST_IDLE;
          w_release_nxt = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    // The level stays high until a release has been fully debounced.
    w_level_nxt = (w_next_state == ST_HELD) || (w_next_state == ST_REPEAT) ||
                  (w_next_state == ST_DEB_RELEASE);
  end

  // State register and shared timing counter; any state change restarts timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_cnt_clr || (w_next_state != r_state)) begin
        r_cnt <= '0;
      end else if (!w_cnt_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Registered outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;
  assign state_code    = r_state;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus randomized button activity,
// compared every cycle against a run-length/age reference model.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int W  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       repeat_en;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       repeat_pulse;
  logic [2:0] state_code;

  // Clock and reset block: 10 ns clock; reset is driven by the stimulus tasks.
  always #5 clk = ~clk;

  button_conditioner #(
    .CNT_W          (W),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .repeat_en    (repeat_en),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .state_code   (state_code)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: synchroniser pipe, accepted level, length of the current
  // run of samples disagreeing with the level, and age of the held phase.
  bit m_s1, m_s2, m_lvl, m_rep, m_press, m_rel, m_rpt;
  int m_run, m_age;

  // Observed-event statistics for the directed scenarios.
  int  n_press, n_rel, n_rpt, n_lvl_hi;
  int  last_press, last_rel, last_rpt, first_rpt;
  bit  chk_spacing;

  // Expected repeat pulse cycles for the held-with-repeat scenario.
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_code();
    if (!m_lvl) return (m_run > 0) ? 3'd1 : 3'd0;
    if (m_run > 0) return 3'd4;
    return m_rep ? 3'd3 : 3'd2;
  endfunction

  task automatic model_step(input bit r, input bit b, input bit e);
    bit smp;
    m_press = 0; m_rel = 0; m_rpt = 0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rep = 0; m_run = 0; m_age = 0;
      return;
    end
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    if (!m_lvl) begin
      // A press is accepted after D+1 consecutive high samples.
      if (smp) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = 1; m_run = 0; m_age = 0; m_rep = 0; m_press = 1;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_run > 0) begin
      // Release debounce: a high sample cancels it and restarts the hold age.
      if (!smp) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = 0; m_run = 0; m_rel = 1;
        end
      end else begin
        m_run = 0; m_age = 0; m_rep = 0;
      end
    end else if (!smp) begin
      m_run = 1; m_rep = 0;
    end else if (m_rep) begin
      if (!e) begin
        m_rep = 0; m_age = 0;
      end else begin
        m_age++;
        if (m_age == RP) begin
          m_rpt = 1; m_age = 0;
        end
      end
    end else begin
      if (m_age < RD) m_age++;
      if (m_age == RD && e) begin
        m_rpt = 1; m_rep = 1; m_age = 0;
      end
    end
  endtask

  // Driver: apply inputs, advance one edge, step the model, compare outputs.
  task automatic cycle(input bit r, input bit b, input bit e);
    rst = r; btn_in = b; repeat_en = e;
    @(posedge clk);
    cyc++;
    model_step(r, b, e);
    #1;
    check_eq("btn_level", btn_level, m_lvl);
    check_eq("press_pulse", press_pulse, m_press);
    check_eq("release_pulse", release_pulse, m_rel);
    check_eq("repeat_pulse", repeat_pulse, m_rpt);
    check_eq("state_code", state_code, model_code());
    if (btn_level) n_lvl_hi++;
    if (press_pulse) begin n_press++; last_press = cyc; end
    if (release_pulse) begin n_rel++; last_rel = cyc; end
    if (repeat_pulse) begin
      if (chk_spacing) begin
        if (exp_q.size() == 0) check_eq("rpt_unexpected", cyc, 0);
        else check_eq("rpt_time", cyc, exp_q.pop_front());
      end
      if (n_rpt == 0) first_rpt = cyc;
      n_rpt++;
      last_rpt = cyc;
    end
  endtask

  task automatic clear_stats();
    n_press = 0; n_rel = 0; n_rpt = 0; n_lvl_hi = 0;
    last_press = -1; last_rel = -1; last_rpt = -1; first_rpt = -1;
  endtask

  task automatic run(input int n, input bit r, input bit b, input bit e);
    for (int i = 0; i < n; i++) cycle(r, b, e);
  endtask

  initial begin
    int t0;
    bit rb, re;
    chk_spacing = 0;
    clear_stats();

    // 1. Reset with the button held: outputs stay zero, then press 7 cycles on.
    run(3, 1, 1, 0);
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_code", state_code, 0);
    check_eq("rst_pulses", {press_pulse, release_pulse, repeat_pulse}, 0);
    clear_stats();
    t0 = cyc;
    run(10, 0, 1, 0);
    check_eq("rst_press_cnt", n_press, 1);
    check_eq("rst_press_lat", last_press - t0, D + 3);
    run(12, 0, 0, 0);

    // 2. Clean press of 30 cycles without repeat.
    clear_stats();
    t0 = cyc;
    run(30, 0, 1, 0);
    check_eq("clean_level_hi", btn_level, 1);
    check_eq("clean_press_lat", last_press - t0, D + 3);
    t0 = cyc;
    run(15, 0, 0, 0);
    check_eq("clean_press_cnt", n_press, 1);
    check_eq("clean_rel_cnt", n_rel, 1);
    check_eq("clean_rel_lat", last_rel - t0, D + 3);
    check_eq("clean_rpt_cnt", n_rpt, 0);
    check_eq("clean_level_lo", btn_level, 0);

    // 3. Short bounces never reach the debounce threshold.
    clear_stats();
    run(2, 0, 1, 0); run(1, 0, 0, 0); run(2, 0, 1, 0); run(10, 0, 0, 0);
    check_eq("bounce_lvl_hi", n_lvl_hi, 0);
    check_eq("bounce_pulses", n_press + n_rel + n_rpt, 0);
    check_eq("bounce_code", state_code, 0);

    // 4. Held with repeat: first repeat RD after press, then every RP.
    clear_stats();
    t0 = cyc;
    for (int k = 0; k < 9; k++) exp_q.push_back(32'(t0 + D + 3 + RD + k * RP));
    chk_spacing = 1;
    run(40, 0, 1, 1);
    run(15, 0, 0, 1);
    chk_spacing = 0;
    check_eq("rpt_press_lat", last_press - t0, D + 3);
    check_eq("rpt_first_lat", first_rpt - last_press, RD);
    check_eq("rpt_cnt", n_rpt, 9);
    check_eq("rpt_left", exp_q.size(), 0);
    check_eq("rpt_before_rel", (last_rpt < last_rel) ? 1 : 0, 1);
    check_eq("rpt_rel_cnt", n_rel, 1);
    exp_q.delete();

    // 5. Release bounce while held, then a clean release.
    clear_stats();
    run(15, 0, 1, 0); run(2, 0, 0, 0); run(10, 0, 1, 0);
    check_eq("relb_rel_cnt", n_rel, 0);
    check_eq("relb_press_cnt", n_press, 1);
    check_eq("relb_level", btn_level, 1);
    t0 = cyc;
    run(15, 0, 0, 0);
    check_eq("relb_rel_cnt2", n_rel, 1);
    check_eq("relb_rel_lat", last_rel - t0, D + 3);

    // 6. Reset while repeating: everything clears with no release pulse.
    clear_stats();
    run(25, 0, 1, 1);
    check_eq("rstrep_code", state_code, 3);
    run(1, 1, 0, 1);
    check_eq("rstrep_out", {btn_level, press_pulse, release_pulse, repeat_pulse}, 0);
    check_eq("rstrep_state", state_code, 0);
    run(15, 0, 0, 1);
    check_eq("rstrep_rel_cnt", n_rel, 0);

    // Randomized activity: bursty button, toggling repeat enable, rare resets.
    rb = 0; re = 0;
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      rb  = ~rb;
      len = (rb && $urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) re = ~re;
        cycle(($urandom_range(0, 299) == 0), rb, re);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
